// File: rtl/vote_pkg.sv
// Shared types and width helpers for the vote qualifier and tally counters.
package vote_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    WAIT_REL,
    LOCKOUT
  } vote_qual_state_t;

  // Bits needed to count up to the larger of two cycle limits.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 32'd1) ? 32'd1 : $clog2(m + 32'd1);
  endfunction

endpackage

// File: rtl/vote_button_qualifier.sv
// Qualifies a single continuously held candidate button into one registered vote pulse,
// rejecting multi-button presses and enforcing full release plus lockout between votes.
module vote_button_qualifier
  import vote_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS    = 4,
  parameter int unsigned HOLD_CYCLES    = 100000000,
  parameter int unsigned LOCKOUT_CYCLES = 0,
  parameter int unsigned IDX_W          = $clog2(NUM_BUTTONS)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_BUTTONS-1:0] button,
  output logic [NUM_BUTTONS-1:0] valid_vote,
  output logic [IDX_W-1:0]       vote_idx,
  output logic                   conflict,
  output logic                   busy
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYCLES, LOCKOUT_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] LOCK_LAST =
    CNT_W'((LOCKOUT_CYCLES == 32'd0) ? 32'd0 : LOCKOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [NUM_BUTTONS-1:0] BTN_ONE = NUM_BUTTONS'(1);

  function automatic logic is_onehot(input logic [NUM_BUTTONS-1:0] b);
    return (b != '0) && ((b & (b - BTN_ONE)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] first_idx(input logic [NUM_BUTTONS-1:0] b);
    logic [IDX_W-1:0] idx_v;
    idx_v = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (b[i]) idx_v = IDX_W'(i);
    end
    return idx_v;
  endfunction

  vote_qual_state_t       state;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic                   held_match;

  assign held_match = (button == (BTN_ONE << idx));

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      valid_vote <= '0;
      vote_idx   <= '0;
      conflict   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      valid_vote <= '0;
      vote_idx   <= '0;
      conflict   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enable && is_onehot(button)) begin
            state <= COUNT;
            idx   <= first_idx(button);
            cnt   <= CNT_ONE;
            busy  <= 1'b1;
          end else if (enable && (button != '0)) begin
            // Simultaneous presses are swallowed silently until released.
            state <= WAIT_REL;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        COUNT: begin
          // Completion takes priority over enable dropping on the same edge.
          if (held_match && (cnt == HOLD_LAST)) begin
            valid_vote <= BTN_ONE << idx;
            vote_idx   <= idx;
            state      <= WAIT_REL;
            cnt        <= '0;
          end else if (!enable) begin
            state <= WAIT_REL;
            cnt   <= '0;
          end else if (held_match) begin
            cnt <= cnt + CNT_ONE;
          end else if (button == '0) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            conflict <= 1'b1;
            state    <= WAIT_REL;
            cnt      <= '0;
          end
        end
        WAIT_REL: begin
          if (button == '0) begin
            cnt <= '0;
            if (LOCKOUT_CYCLES > 0) begin
              state <= LOCKOUT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        LOCKOUT: begin
          if (cnt == LOCK_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vote_button_qualifier.sv
// Directed and randomized checks of two qualifier instances (with and without lockout)
// against a phase-based reference model.
module tb_vote_button_qualifier;

  localparam int NB   = 4;
  localparam int HOLD = 5;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [NB-1:0] button;

  logic [NB-1:0] vv_a, vv_b;
  logic [1:0]    vi_a, vi_b;
  logic          cf_a, cf_b, bz_a, bz_b;

  int tests = 0;
  int fails = 0;

  // Reference model, one slot per instance (0: lockout 3, 1: no lockout).
  int            run      [2];
  int            who      [2];
  int            lock_left[2];
  bit            need_rel [2];
  logic [NB-1:0] m_vv     [2];
  int            m_vi     [2];
  bit            m_cf     [2];

  vote_button_qualifier #(
    .NUM_BUTTONS   (NB),
    .HOLD_CYCLES   (HOLD),
    .LOCKOUT_CYCLES(3)
  ) dut_a (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .button    (button),
    .valid_vote(vv_a),
    .vote_idx  (vi_a),
    .conflict  (cf_a),
    .busy      (bz_a)
  );

  vote_button_qualifier #(
    .NUM_BUTTONS   (NB),
    .HOLD_CYCLES   (HOLD),
    .LOCKOUT_CYCLES(0)
  ) dut_b (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .button    (button),
    .valid_vote(vv_b),
    .vote_idx  (vi_b),
    .conflict  (cf_b),
    .busy      (bz_b)
  );

  always #5 clock = ~clock;

  function automatic int lock_of(input int k);
    return (k == 0) ? 3 : 0;
  endfunction

  task automatic model_edge();
    logic [NB-1:0] mine;
    int            ones;
    for (int k = 0; k < 2; k++) begin
      m_vv[k] = '0;
      m_vi[k] = 0;
      m_cf[k] = 1'b0;
      mine    = 4'(1) << who[k];
      if (reset) begin
        run[k]       = 0;
        need_rel[k]  = 1'b0;
        lock_left[k] = 0;
      end else if (lock_left[k] > 0) begin
        lock_left[k]--;
      end else if (need_rel[k]) begin
        if (button == '0) begin
          need_rel[k]  = 1'b0;
          lock_left[k] = lock_of(k);
        end
      end else if (run[k] > 0) begin
        if (button == mine && run[k] + 1 == HOLD) begin
          m_vv[k]     = mine;
          m_vi[k]     = who[k];
          run[k]      = 0;
          need_rel[k] = 1'b1;
        end else if (!enable) begin
          run[k]      = 0;
          need_rel[k] = 1'b1;
        end else if (button == mine) begin
          run[k]++;
        end else if (button == '0) begin
          run[k] = 0;
        end else begin
          m_cf[k]     = 1'b1;
          run[k]      = 0;
          need_rel[k] = 1'b1;
        end
      end else if (enable) begin
        ones = $countones(button);
        if (ones == 1) begin
          run[k] = 1;
          for (int i = 0; i < NB; i++) if (button[i]) who[k] = i;
        end else if (ones >= 2) begin
          need_rel[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_busy(input int k);
    return 32'((run[k] > 0) || need_rel[k] || (lock_left[k] > 0));
  endfunction

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("a.valid_vote", 32'(vv_a), 32'(m_vv[0]));
    chk("a.vote_idx",   32'(vi_a), 32'(m_vi[0]));
    chk("a.conflict",   32'(cf_a), 32'(m_cf[0]));
    chk("a.busy",       32'(bz_a), exp_busy(0));
    chk("b.valid_vote", 32'(vv_b), 32'(m_vv[1]));
    chk("b.vote_idx",   32'(vi_b), 32'(m_vi[1]));
    chk("b.conflict",   32'(cf_b), 32'(m_cf[1]));
    chk("b.busy",       32'(bz_b), exp_busy(1));
  endtask

  task automatic hold(input logic [NB-1:0] b, input int n);
    button = b;
    repeat (n) step();
  endtask

  initial begin
    int            seg_len;
    int            r;
    logic [NB-1:0] pat;

    for (int k = 0; k < 2; k++) begin
      run[k] = 0; who[k] = 0; lock_left[k] = 0; need_rel[k] = 1'b0;
    end
    reset  = 1'b1;
    enable = 1'b1;
    button = '0;
    #1;
    step();
    step();
    reset = 1'b0;

    // Long single press, then release through lockout.
    hold(4'b0100, 8);
    hold(4'b0000, 6);

    // Short press is discarded, then a full press votes.
    hold(4'b0001, 4);
    hold(4'b0000, 2);
    hold(4'b0001, 5);
    hold(4'b0000, 6);

    // Second button joins mid-hold.
    hold(4'b0001, 2);
    hold(4'b0011, 3);
    hold(4'b0000, 6);

    // Enable drops at the third edge of a hold.
    button = 4'b1000;
    step();
    step();
    enable = 1'b0;
    step();
    step();
    enable = 1'b1;
    hold(4'b1000, 4);
    hold(4'b0000, 5);
    hold(4'b1000, 5);
    hold(4'b0000, 6);

    // Reset at the fourth edge of a hold; the hold continues afterwards.
    hold(4'b0010, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    hold(4'b0010, 7);
    hold(4'b0000, 6);

    // Two votes separated by a single release cycle.
    hold(4'b0100, 5);
    hold(4'b0000, 1);
    hold(4'b0100, 5);
    hold(4'b0000, 6);

    // Randomized segments biased towards single-button holds.
    for (int s = 0; s < 400; s++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)      pat = 4'(1) << $urandom_range(0, NB - 1);
      else if (r < 7) pat = '0;
      else            pat = 4'($urandom_range(0, 15));
      seg_len = int'($urandom_range(1, 8));
      enable  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 39) == 0) begin
        reset  = 1'b1;
        button = pat;
        step();
        reset = 1'b0;
      end
      hold(pat, seg_len);
    end
    enable = 1'b1;
    hold(4'b0000, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
